bmem_line_adapter: RTL and testbench

Initiator-side adapter between a cache's 256-bit line port and the 64-bit burst banked-memory interface. It serializes a line write into a 4-beat write burst. For a read, it issues a single-cycle read request and deserializes the 4 returned beats into one line. It sits inside `cpu_top`, below the cache, and drives the `bmem_*` pins that the bench's banked memory model responds to. It supports one outstanding transaction.

---
 rtl/bmem_pkg.sv | 27 ++
 rtl/bmem_line_adapter.sv | 128 ++++++++++++
 tb/tb_bmem_line_adapter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_pkg.sv
// +---------------------------------------------------------------------------
// | bmem_pkg : widths and line/beat types shared by the cache-side memory path
// | Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

package bmem_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFS_W  = $clog2(LINE_W / 8);

  typedef logic [BEAT_W-1:0]  beat_t;
  typedef beat_t [BEATS-1:0]  line_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // Bursts always start on a line boundary.
  function automatic addr_t line_align(input addr_t a);
    return {a[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bmem_line_adapter.sv
// +---------------------------------------------------------------------------
// | bmem_line_adapter : 256-bit cache line port to 4-beat 64-bit burst memory
// | Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module bmem_line_adapter
  import bmem_pkg::*;
#(
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_BURST = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e            state_q, state_d;
  addr_t             addr_q, addr_d;
  line_t             line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rd_hit_w;
  logic              stray_beat_w;
  logic              both_req_w;
  logic              unused_w;

  assign rd_hit_w     = bmem_rvalid && (bmem_raddr == addr_q);
  assign stray_beat_w = (state_q == S_RD_WAIT) && bmem_rvalid && (bmem_raddr != addr_q);
  assign both_req_w   = (state_q == S_IDLE) && dfp_read && dfp_write;
  assign unused_w     = ^dfp_addr[OFS_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Read wins when both are requested.
        if (dfp_read) begin
          addr_d  = line_align(dfp_addr);
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end else if (dfp_write) begin
          addr_d  = line_align(dfp_addr);
          line_d  = line_t'(dfp_wdata);
          cnt_d   = '0;
          state_d = S_WR_BURST;
        end
      end
      S_RD_REQ: begin
        if (bmem_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_hit_w) begin
          line_d[cnt_q] = bmem_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_WR_BURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on inputs.
  assign dfp_resp   = (state_q == S_DONE);
  assign dfp_rdata  = dfp_resp ? LINE_W'(line_q) : '0;
  assign bmem_read  = (state_q == S_RD_REQ);
  assign bmem_write = (state_q == S_WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? line_q[cnt_q] : '0;

  always @(posedge clk) begin
    if (ASSERT_EN && !rst) begin
      a_one_request: assert (!both_req_w)
        else $error("bmem_line_adapter: dfp_read and dfp_write both high");
      a_raddr_match: assert (!stray_beat_w)
        else $error("bmem_line_adapter: read beat with mismatched raddr dropped");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bmem_line_adapter.sv
// +---------------------------------------------------------------------------
// | tb_bmem_line_adapter : directed self-checking bench for bmem_line_adapter
// | Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module tb_bmem_line_adapter;
  import bmem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  int checks = 0;
  int errors = 0;

  // Stray-beat assertion is observed through its flag so the run keeps going.
  bmem_line_adapter #(.ASSERT_EN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic beat_in(input logic v, input logic [31:0] ra, input logic [63:0] d);
    bmem_rvalid = v;
    bmem_raddr  = ra;
    bmem_rdata  = d;
  endtask

  task automatic test_reset();
    logic [LINE_W+ADDR_W+BEAT_W+2:0] all_out;
    rst = 1'b1; dfp_addr = '0; dfp_read = 0; dfp_write = 0; dfp_wdata = '0;
    bmem_ready = 0; beat_in(0, '0, '0);
    #2;
    all_out = {dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", all_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got %b expected 000", {dfp_resp, bmem_read, bmem_write});
    end
  endtask

  task automatic test_write();
    beat_t a [4];
    line_t l;
    logic ew, er;
    a[0] = 64'hA0A0_0000_1111_0000; a[1] = 64'hA1A1_2222_0000_0001;
    a[2] = 64'hA2A2_3333_4444_0002; a[3] = 64'hA3A3_5555_6666_0003;
    for (int k = 0; k < 4; k++) l[k] = a[k];
    dfp_addr = 32'h1234_5678; dfp_wdata = l; dfp_write = 1; bmem_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ew = (i >= 1 && i <= 4);
      er = (i == 5);
      checks++;
      if ({bmem_write, bmem_read, dfp_resp} !== {ew, 1'b0, er}) begin
        errors++;
        $display("FAIL write_ctrl cyc %0d got w/r/resp %b expected %b", i,
                 {bmem_write, bmem_read, dfp_resp}, {ew, 1'b0, er});
      end
      if (ew) begin
        checks++;
        if (bmem_addr !== 32'h1234_5660 || bmem_wdata !== a[i-1]) begin
          errors++;
          $display("FAIL write_beat cyc %0d got %h/%h expected 12345660/%h", i,
                   bmem_addr, bmem_wdata, a[i-1]);
        end
      end
      if (i == 5) dfp_write = 0;
    end
  endtask

  task automatic test_write_stall();
    beat_t c [4];
    line_t l;
    int idx [5];
    logic ew, er;
    c[0] = 64'hC000_0000_0000_00C0; c[1] = 64'hC111_1111_1111_11C1;
    c[2] = 64'hC222_2222_2222_22C2; c[3] = 64'hC333_3333_3333_33C3;
    idx = '{0, 1, 2, 2, 3};
    for (int k = 0; k < 4; k++) l[k] = c[k];
    dfp_addr = 32'hABCD_EF3F; dfp_wdata = l; dfp_write = 1; bmem_ready = 1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      ew = (i >= 1 && i <= 5);
      er = (i == 6);
      checks++;
      if ({bmem_write, dfp_resp} !== {ew, er}) begin
        errors++;
        $display("FAIL stall_ctrl cyc %0d got w/resp %b expected %b", i,
                 {bmem_write, dfp_resp}, {ew, er});
      end
      if (ew) begin
        checks++;
        if (bmem_addr !== 32'hABCD_EF20 || bmem_wdata !== c[idx[i-1]]) begin
          errors++;
          $display("FAIL stall_beat cyc %0d got %h/%h expected abcdef20/%h", i,
                   bmem_addr, bmem_wdata, c[idx[i-1]]);
        end
      end
      bmem_ready = (i != 3);
      if (i == 6) dfp_write = 0;
    end
  endtask

  task automatic test_read_gaps();
    beat_t b [4];
    line_t l;
    logic er, ep;
    b[0] = 64'hB000_0000_DEAD_0000; b[1] = 64'hB111_0000_BEEF_0001;
    b[2] = 64'hB222_0000_CAFE_0002; b[3] = 64'hB333_0000_F00D_0003;
    for (int k = 0; k < 4; k++) l[k] = b[k];
    dfp_addr = 32'h0000_1000; dfp_read = 1; bmem_ready = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      er = (i <= 4);
      ep = (i == 13);
      checks++;
      if ({bmem_read, bmem_write, dfp_resp} !== {er, 1'b0, ep}) begin
        errors++;
        $display("FAIL read_ctrl cyc %0d got r/w/resp %b expected %b", i,
                 {bmem_read, bmem_write, dfp_resp}, {er, 1'b0, ep});
      end
      if (er) begin
        checks++;
        if (bmem_addr !== 32'h0000_1000) begin
          errors++; $display("FAIL read_addr cyc %0d got %h expected 00001000", i, bmem_addr);
        end
      end
      if (ep) begin
        checks++;
        if (dfp_rdata !== LINE_W'(l)) begin
          errors++; $display("FAIL read_line got %h expected %h", dfp_rdata, LINE_W'(l));
        end
        dfp_read = 0;
      end
      bmem_ready = (i >= 4);
      case (i)
        5:       beat_in(1, 32'h1000, b[0]);
        7:       beat_in(1, 32'h1000, b[1]);
        9:       beat_in(1, 32'h1000, b[2]);
        12:      beat_in(1, 32'h1000, b[3]);
        default: beat_in(0, 32'h0, 64'h0);
      endcase
    end
  endtask

  task automatic test_stray();
    beat_t d [4];
    line_t l;
    d[0] = 64'hD0D0_0101_0101_0101; d[1] = 64'hD1D1_0202_0202_0202;
    d[2] = 64'hD2D2_0303_0303_0303; d[3] = 64'hD3D3_0404_0404_0404;
    for (int k = 0; k < 4; k++) l[k] = d[k];
    beat_in(1, 32'h1000, 64'hEEEE_EEEE_EEEE_EEEE);
    bmem_ready = 1;
    @(negedge clk);
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      errors++; $display("FAIL stray_idle got %b expected 000", {dfp_resp, bmem_read, bmem_write});
    end
    beat_in(0, 32'h0, 64'h0);
    dfp_addr = 32'h0000_1010; dfp_read = 1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      case (i)
        1: beat_in(1, 32'h1000, 64'hBAD0_BAD0_BAD0_BAD0);
        2: beat_in(1, 32'h1000, d[0]);
        3: beat_in(1, 32'h2000, 64'hBAD1_BAD1_BAD1_BAD1);
        4: beat_in(1, 32'h1000, d[1]);
        5: beat_in(1, 32'h1000, d[2]);
        6: beat_in(1, 32'h1000, d[3]);
        default: beat_in(0, 32'h0, 64'h0);
      endcase
      #1;
      if (i == 2 || i == 3) begin
        checks++;
        if (dut.stray_beat_w !== (i == 3)) begin
          errors++; $display("FAIL stray_flag cyc %0d got %b expected %b", i,
                             dut.stray_beat_w, (i == 3));
        end
      end
    end
    checks++;
    if (dfp_resp !== 1'b1 || dfp_rdata !== LINE_W'(l)) begin
      errors++; $display("FAIL stray_line got resp %b line %h expected 1 %h",
                         dfp_resp, dfp_rdata, LINE_W'(l));
    end
    dfp_read = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [LINE_W+ADDR_W+BEAT_W+2:0] all_out;
    int seen;
    dfp_addr = 32'h0000_1000; dfp_read = 1; bmem_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      case (i)
        2:       beat_in(1, 32'h1000, 64'h1111_0000_0000_0000);
        3:       beat_in(1, 32'h1000, 64'h2222_0000_0000_0001);
        default: beat_in(0, 32'h0, 64'h0);
      endcase
    end
    @(negedge clk);
    beat_in(0, 32'h0, 64'h0);
    rst = 1'b1; dfp_read = 0;
    #1;
    all_out = {dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL midreset_outputs got %h expected 0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) beat_in(1, 32'h1000, 64'h3333_0000_0000_0002);
      else if (i == 2) beat_in(1, 32'h1000, 64'h4444_0000_0000_0003);
      else beat_in(0, 32'h0, 64'h0);
      @(negedge clk);
      if (dfp_resp || bmem_read || bmem_write) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset_quiet got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    beat_t e [4];
    beat_t f [4];
    line_t le, lf;
    logic ew, er, ep;
    for (int k = 0; k < 4; k++) begin
      e[k] = 64'hE000_0000_0000_0000 | 64'(k);
      f[k] = 64'hF000_0000_0000_0000 | 64'(k << 8);
      le[k] = e[k];
      lf[k] = f[k];
    end
    dfp_addr = 32'h0000_0040; dfp_wdata = le; dfp_write = 1; bmem_ready = 1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      ew = (i <= 4);
      er = (i == 7);
      ep = (i == 5 || i == 12);
      checks++;
      if ({bmem_write, bmem_read, dfp_resp} !== {ew, er, ep}) begin
        errors++;
        $display("FAIL b2b_ctrl cyc %0d got w/r/resp %b expected %b", i,
                 {bmem_write, bmem_read, dfp_resp}, {ew, er, ep});
      end
      if (ew) begin
        checks++;
        if (bmem_addr !== 32'h0000_0040 || bmem_wdata !== e[i-1]) begin
          errors++;
          $display("FAIL b2b_wbeat cyc %0d got %h/%h expected 00000040/%h", i,
                   bmem_addr, bmem_wdata, e[i-1]);
        end
      end
      if (er) begin
        checks++;
        if (bmem_addr !== 32'h0000_0080) begin
          errors++; $display("FAIL b2b_raddr got %h expected 00000080", bmem_addr);
        end
      end
      if (i == 12) begin
        checks++;
        if (dfp_rdata !== LINE_W'(lf)) begin
          errors++; $display("FAIL b2b_line got %h expected %h", dfp_rdata, LINE_W'(lf));
        end
        dfp_read = 0;
      end
      if (i == 5) begin
        dfp_write = 0; dfp_read = 1; dfp_addr = 32'h0000_009C;
      end
      if (i >= 8 && i <= 11) beat_in(1, 32'h0000_0080, f[i-8]);
      else beat_in(0, 32'h0, 64'h0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_stall();
    test_read_gaps();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
